// File: rtl/clken_gen.sv
// clken_gen: multi-channel fractional clock-enable generator and reset sequencer.
// Each channel emits num[i] evenly spread single-cycle enables per frame of DEN cycles.
// Optional macro CLKEN_LATE_EN: adds a one-cycle-delayed copy of clken on clken_late;
// when undefined, clken_late is tied to zero.
module clken_gen #(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned ACC_W      = 8,
  parameter int unsigned DEN        = 25,
  parameter int unsigned RST_FRAMES = 4
) (
  input  logic                      clk100,
  input  logic                      reset,
  input  logic [NUM_CH*ACC_W-1:0]   num,
  input  logic [NUM_CH-1:0]         en,
  input  logic                      rst_req,
  output logic [NUM_CH-1:0]         clken,
  output logic [NUM_CH-1:0]         clken_late,
  output logic                      frame_sync,
  output logic                      sys_reset
);

  localparam int unsigned POS_W = (DEN > 1) ? $clog2(DEN) : 1;
  localparam int unsigned SUM_W = ACC_W + 1;
  localparam int unsigned CNT_W = (RST_FRAMES > 0) ? $clog2(RST_FRAMES + 1) : 1;

  localparam logic [POS_W-1:0] LAST_POS = POS_W'(DEN - 1);
  localparam logic [ACC_W-1:0] DEN_N    = ACC_W'(DEN);
  localparam logic [SUM_W-1:0] DEN_S    = SUM_W'(DEN);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RST_FRAMES);

  logic [POS_W-1:0] pos;
  logic [POS_W-1:0] pos_next;
  logic             at_start;
  logic             at_last;

  logic [SUM_W-1:0] acc      [NUM_CH];
  logic [SUM_W-1:0] acc_next [NUM_CH];
  logic [SUM_W-1:0] sum      [NUM_CH];
  logic [ACC_W-1:0] n        [NUM_CH];
  logic [ACC_W-1:0] num_f    [NUM_CH];
  logic [ACC_W-1:0] n_cur    [NUM_CH];
  logic [NUM_CH-1:0] raw;

  logic [1:0]       sync;
  logic             rq;
  logic [CNT_W-1:0] cnt;

  assign at_start = (pos == '0);
  assign at_last  = (pos == LAST_POS);
  assign pos_next = at_last ? '0 : pos + POS_W'(1);
  assign rq       = sync[1];

  // Per-channel numerator clamp/latch, pulse decision and accumulator step.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      num_f[i]    = num[i*ACC_W +: ACC_W];
      n_cur[i]    = n[i];
      if (at_start) n_cur[i] = (num_f[i] > DEN_N) ? DEN_N : num_f[i];
      raw[i]      = (acc[i] < {1'b0, n_cur[i]});
      sum[i]      = acc[i] + {1'b0, n_cur[i]};
      acc_next[i] = (sum[i] >= DEN_S) ? (sum[i] - DEN_S) : sum[i];
      if (at_last) acc_next[i] = '0;
    end
  end

  // Frame position, accumulators, latched numerators and enable outputs.
  always_ff @(posedge clk100) begin
    if (reset) begin
      pos        <= '0;
      clken      <= '0;
      frame_sync <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        acc[i] <= '0;
        n[i]   <= '0;
      end
    end else begin
      pos        <= pos_next;
      clken      <= raw & en;
      frame_sync <= at_start;
      for (int i = 0; i < NUM_CH; i++) begin
        acc[i] <= acc_next[i];
        n[i]   <= n_cur[i];
      end
    end
  end

  // Reset request synchroniser and frame-counted reset stretcher.
  always_ff @(posedge clk100) begin
    if (reset) begin
      sync      <= 2'b11;
      cnt       <= CNT_LOAD;
      sys_reset <= 1'b1;
    end else begin
      sync      <= {sync[0], rst_req};
      sys_reset <= rq | (cnt != '0);
      if (rq) begin
        cnt <= CNT_LOAD;
      end else if (frame_sync && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

`ifdef CLKEN_LATE_EN
  // One-cycle delayed enables for second-half-of-cycle write strobes.
  always_ff @(posedge clk100) begin
    if (reset) clken_late <= '0;
    else       clken_late <= clken;
  end
`else
  assign clken_late = '0;
`endif

endmodule
